// File: rtl/data_ram_slave_pkg.sv
// Shared definitions for the data-memory responder: request direction codes,
// byte-lane select patterns, FSM states and the lane/alignment legality check.
package data_ram_slave_pkg;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  localparam logic [3:0] SEL_B0 = 4'b0001;
  localparam logic [3:0] SEL_B1 = 4'b0010;
  localparam logic [3:0] SEL_B2 = 4'b0100;
  localparam logic [3:0] SEL_B3 = 4'b1000;
  localparam logic [3:0] SEL_H0 = 4'b0011;
  localparam logic [3:0] SEL_H1 = 4'b1100;
  localparam logic [3:0] SEL_W  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // An empty lane mask is only meaningful as a null store.
  function automatic logic sel_misaligned(input logic [3:0] sel,
                                          input logic [1:0] addr_lo,
                                          input logic       rw);
    logic bad;
    case (sel)
      SEL_B0, SEL_B1, SEL_B2, SEL_B3: bad = 1'b0;
      SEL_H0, SEL_H1:                 bad = addr_lo[0];
      SEL_W:                          bad = (addr_lo != 2'b00);
      4'b0000:                        bad = (rw == MEM_READ);
      default:                        bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_sram_array.sv
// Single-port word-organised SRAM with byte write enables; read and write
// both take effect on the rising clock edge.
module data_sram_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_re,
  input  logic [3:0]            i_we,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(1 << ADDR_WIDTH)-1];
  logic [31:0] r_rdata;

  // Byte-lane write and registered read port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_ram_slave.sv
// Data-memory responder: accepts one load/store at a time, adds WAIT_CYCLES wait
// states, then pulses mem_ready_o with read data or a fault indication.
module data_ram_slave
  import data_ram_slave_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_cs_i,
  input  logic        mem_rw_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        mem_err_o
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_rw;
  logic [31:0] r_addr;
  logic [3:0]  r_sel;
  logic [31:0] r_wdata;
  logic        r_ready, r_err, r_rd_valid;
  logic        w_latch, w_enter_resp, w_err, w_re;
  logic        w_rw;
  logic [31:0] w_addr;
  logic [3:0]  w_sel;
  logic [3:0]  w_we;
  logic [31:0] w_ram_q;

  // While idle the live request is examined so a zero-wait read can hit the
  // array on its acceptance edge; afterwards the latched copy is used.
  assign w_rw   = (r_state == ST_IDLE) ? mem_rw_i   : r_rw;
  assign w_addr = (r_state == ST_IDLE) ? mem_addr_i : r_addr;
  assign w_sel  = (r_state == ST_IDLE) ? mem_sel_i  : r_sel;

  assign w_err = (w_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2])
               || sel_misaligned(w_sel, w_addr[1:0], w_rw);

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_cs_i) begin
          w_latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_cnt_nxt   = WAIT_INIT;
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_enter_resp = (w_state_nxt == ST_RESP);
  assign w_re         = w_enter_resp && (w_rw == MEM_READ) && !w_err;
  assign w_we         = ((r_state == ST_RESP) && (r_rw == MEM_WRITE) && !r_err) ? r_sel : 4'b0000;

  // State, counter, request latch and response flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_rw       <= MEM_READ;
      r_addr     <= 32'h0000_0000;
      r_sel      <= 4'b0000;
      r_wdata    <= 32'h0000_0000;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ready    <= w_enter_resp;
      r_err      <= w_enter_resp && w_err;
      r_rd_valid <= w_re;
      if (w_latch) begin
        r_rw    <= mem_rw_i;
        r_addr  <= mem_addr_i;
        r_sel   <= mem_sel_i;
        r_wdata <= mem_wdata_i;
      end
    end
  end

  data_sram_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk     (clk),
    .i_addr  (w_addr[ADDR_WIDTH+1:2]),
    .i_re    (w_re),
    .i_we    (w_we),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

  assign mem_rdata_o = r_rd_valid ? w_ram_q : 32'h0000_0000;
  assign mem_ready_o = r_ready;
  assign mem_err_o   = r_err;

endmodule
